// File: rtl/reg_target_seq_pkg.sv
// Shared definitions for the target power/reset sequencer: state codes,
// register map constants and power-on timing defaults.
package reg_target_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PWR_OFF  = 3'd1,
    ST_RST_HOLD = 3'd2,
    ST_ARM_WAIT = 3'd3
  } seq_state_t;

  localparam logic [5:0]  SEQCTRL_ADDR = 6'd45;
  localparam logic [5:0]  SEQTIME_ADDR = 6'd46;
  localparam logic [15:0] SEQCTRL_LEN  = 16'd1;
  localparam logic [15:0] SEQTIME_LEN  = 16'd6;

  localparam logic [15:0] OFF_TIME_DEFAULT  = 16'd1000;
  localparam logic [15:0] RST_TIME_DEFAULT  = 16'd100;
  localparam logic [15:0] ARM_DELAY_DEFAULT = 16'd0;

  localparam int CTRL_START   = 0;
  localparam int CTRL_ABORT   = 1;
  localparam int CTRL_CLRDONE = 7;

  function automatic logic [7:0] status_byte(input logic aborted, input logic done,
                                             input seq_state_t st, input logic busy);
    return {2'b00, aborted, done, st, busy};
  endfunction

endpackage

// File: rtl/reg_target_seq_timebase.sv
// Prescaled segment timer: loads a tick count on state entry and flags the
// final cycle of the segment, both registered and one cycle ahead.
module seq_timebase #(
  parameter int TICK_DIV = 96
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        run,
  input  logic [15:0] load_val,
  output logic        last,
  output logic        last_nxt
);

  localparam logic [7:0] TICK_LAST = 8'(TICK_DIV - 1);

  logic [7:0]  presc, presc_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic        tick;

  // last_nxt predicts whether the coming cycle ends the segment, so the
  // sequencer can register its arm pulse instead of decoding it.
  always_comb begin
    tick      = (presc == TICK_LAST);
    presc_nxt = 8'd0;
    cnt_nxt   = cnt;
    last_nxt  = 1'b0;
    if (load) begin
      cnt_nxt  = load_val;
      last_nxt = (load_val == 16'd0);
    end else if (run) begin
      presc_nxt = tick ? 8'd0 : presc + 8'd1;
      cnt_nxt   = tick ? cnt - 16'd1 : cnt;
      last_nxt  = (presc_nxt == TICK_LAST) && (cnt_nxt == 16'd0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= 8'd0;
      cnt   <= 16'd0;
      last  <= 1'b0;
    end else begin
      presc <= presc_nxt;
      cnt   <= cnt_nxt;
      last  <= last_nxt;
    end
  end

endmodule

// File: rtl/reg_target_seq.sv
// Register-mapped target power/reset sequencer: bus decode, timing registers,
// shadow copies and the power-off / reset-hold / arm-wait state machine.
module reg_target_seq
  import reg_target_seq_pkg::*;
#(
  parameter logic [5:0] ADDR_SEQCTRL = SEQCTRL_ADDR,
  parameter logic [5:0] ADDR_SEQTIME = SEQTIME_ADDR,
  parameter int         TICK_DIV     = 96
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic [5:0]  reg_address,
  input  logic [15:0] reg_bytecnt,
  input  logic [7:0]  reg_datai,
  output logic [7:0]  reg_datao,
  input  logic [15:0] reg_size,
  input  logic        reg_read,
  input  logic        reg_write,
  input  logic        reg_addrvalid,
  input  logic [5:0]  reg_hypaddress,
  output logic [15:0] reg_hyplen,
  output logic        target_npower_o,
  output logic        nrst_enable_o,
  output logic        nrst_o,
  output logic        glitch_arm_o,
  output logic        busy_o
);

  logic [15:0] off_time, rst_time, arm_delay;
  logic [15:0] rst_shadow, arm_shadow;
  seq_state_t  state, state_d;
  logic        done, aborted;
  logic        ctrl_wr, time_wr, start_req, abort_req, clr_req;
  logic        seg_load, seg_run, seg_last, seg_last_nxt;
  logic [15:0] seg_val;
  logic        unused_bus;

  assign unused_bus = ^reg_size;

  assign ctrl_wr   = reg_write && reg_addrvalid && (reg_address == ADDR_SEQCTRL)
                     && (reg_bytecnt == 16'd0);
  assign time_wr   = reg_write && reg_addrvalid && (reg_address == ADDR_SEQTIME)
                     && (reg_bytecnt < 16'd6);
  assign start_req = ctrl_wr && reg_datai[CTRL_START];
  assign abort_req = ctrl_wr && reg_datai[CTRL_ABORT];
  assign clr_req   = ctrl_wr && reg_datai[CTRL_CLRDONE];

  always_comb begin
    if (reg_hypaddress == ADDR_SEQCTRL)      reg_hyplen = SEQCTRL_LEN;
    else if (reg_hypaddress == ADDR_SEQTIME) reg_hyplen = SEQTIME_LEN;
    else                                     reg_hyplen = 16'd0;
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      off_time  <= OFF_TIME_DEFAULT;
      rst_time  <= RST_TIME_DEFAULT;
      arm_delay <= ARM_DELAY_DEFAULT;
    end else if (time_wr) begin
      case (reg_bytecnt[2:0])
        3'd0:    off_time[7:0]   <= reg_datai;
        3'd1:    off_time[15:8]  <= reg_datai;
        3'd2:    rst_time[7:0]   <= reg_datai;
        3'd3:    rst_time[15:8]  <= reg_datai;
        3'd4:    arm_delay[7:0]  <= reg_datai;
        3'd5:    arm_delay[15:8] <= reg_datai;
        default: ;
      endcase
    end
  end

  // The first segment loads the live off_time; later segments use the
  // shadows captured at start so mid-sequence writes only affect the next run.
  always_comb begin
    state_d = state;
    seg_val = 16'd0;
    if (abort_req) begin
      state_d = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:     if (start_req) begin state_d = ST_PWR_OFF;  seg_val = off_time;   end
        ST_PWR_OFF:  if (seg_last)  begin state_d = ST_RST_HOLD; seg_val = rst_shadow; end
        ST_RST_HOLD: if (seg_last)  begin state_d = ST_ARM_WAIT; seg_val = arm_shadow; end
        ST_ARM_WAIT: if (seg_last)  state_d = ST_IDLE;
        default:     state_d = ST_IDLE;
      endcase
    end
    seg_load = (state_d != state) && (state_d != ST_IDLE);
    seg_run  = (state_d != ST_IDLE) && !seg_load;
  end

  seq_timebase #(.TICK_DIV(TICK_DIV)) u_timebase (
    .clk      (clk),
    .rst      (reset_i),
    .load     (seg_load),
    .run      (seg_run),
    .load_val (seg_val),
    .last     (seg_last),
    .last_nxt (seg_last_nxt)
  );

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state           <= ST_IDLE;
      rst_shadow      <= 16'd0;
      arm_shadow      <= 16'd0;
      done            <= 1'b0;
      aborted         <= 1'b0;
      target_npower_o <= 1'b0;
      nrst_enable_o   <= 1'b0;
      nrst_o          <= 1'b1;
      glitch_arm_o    <= 1'b0;
      busy_o          <= 1'b0;
    end else begin
      state <= state_d;
      if (state == ST_IDLE && state_d == ST_PWR_OFF) begin
        rst_shadow <= rst_time;
        arm_shadow <= arm_delay;
      end
      if (clr_req) begin
        done    <= 1'b0;
        aborted <= 1'b0;
      end
      if (abort_req)                              aborted <= 1'b1;
      else if (state == ST_ARM_WAIT && seg_last)  done    <= 1'b1;
      glitch_arm_o <= (state_d == ST_ARM_WAIT) && seg_last_nxt;
      busy_o       <= (state_d != ST_IDLE);
      case (state_d)
        ST_PWR_OFF:  begin target_npower_o <= 1'b1; nrst_enable_o <= 1'b1; nrst_o <= 1'b0; end
        ST_RST_HOLD: begin target_npower_o <= 1'b0; nrst_enable_o <= 1'b1; nrst_o <= 1'b0; end
        default:     begin target_npower_o <= 1'b0; nrst_enable_o <= 1'b0; nrst_o <= 1'b1; end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      reg_datao <= 8'd0;
    end else begin
      reg_datao <= 8'd0;
      if (reg_read && reg_addrvalid) begin
        if (reg_address == ADDR_SEQCTRL && reg_bytecnt == 16'd0) begin
          reg_datao <= status_byte(aborted, done, state, busy_o);
        end else if (reg_address == ADDR_SEQTIME) begin
          case (reg_bytecnt)
            16'd0:   reg_datao <= off_time[7:0];
            16'd1:   reg_datao <= off_time[15:8];
            16'd2:   reg_datao <= rst_time[7:0];
            16'd3:   reg_datao <= rst_time[15:8];
            16'd4:   reg_datao <= arm_delay[7:0];
            16'd5:   reg_datao <= arm_delay[15:8];
            default: reg_datao <= 8'd0;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_target_seq.sv
// Scoreboard bench for reg_target_seq: read data and arm pulses are checked by
// a monitor against queued expectations; pin levels against a phase model.
module tb_reg_target_seq;

  localparam logic [5:0] A_CTRL = 6'd45;
  localparam logic [5:0] A_TIME = 6'd46;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic [5:0]  reg_address = '0;
  logic [15:0] reg_bytecnt = '0;
  logic [7:0]  reg_datai = '0;
  logic [7:0]  reg_datao;
  logic [15:0] reg_size = 16'd1;
  logic        reg_read = 1'b0;
  logic        reg_write = 1'b0;
  logic        reg_addrvalid = 1'b0;
  logic [5:0]  reg_hypaddress = '0;
  logic [15:0] reg_hyplen;
  logic        target_npower_o, nrst_enable_o, nrst_o, glitch_arm_o, busy_o;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   rd_seen = 1'b0;
  logic [7:0] rd_q[$];
  string      rd_name_q[$];
  int         arm_q[$];

  reg_target_seq #(.TICK_DIV(4)) dut (
    .clk             (clk),
    .reset_i         (reset_i),
    .reg_address     (reg_address),
    .reg_bytecnt     (reg_bytecnt),
    .reg_datai       (reg_datai),
    .reg_datao       (reg_datao),
    .reg_size        (reg_size),
    .reg_read        (reg_read),
    .reg_write       (reg_write),
    .reg_addrvalid   (reg_addrvalid),
    .reg_hypaddress  (reg_hypaddress),
    .reg_hyplen      (reg_hyplen),
    .target_npower_o (target_npower_o),
    .nrst_enable_o   (nrst_enable_o),
    .nrst_o          (nrst_o),
    .glitch_arm_o    (glitch_arm_o),
    .busy_o          (busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    rd_seen = reg_read && reg_addrvalid && !reset_i;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: consumes read and arm expectations as the DUT presents them.
  always @(negedge clk) begin
    if (rd_seen) begin
      if (rd_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL read: data %0h with no expectation queued", reg_datao);
      end else begin
        check(rd_name_q.pop_front(), {24'd0, reg_datao}, {24'd0, rd_q.pop_front()});
      end
    end
    if (glitch_arm_o) begin
      if (arm_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL arm: unexpected pulse at cycle %0d, none required", cyc);
      end else begin
        check("arm pulse cycle", cyc, arm_q.pop_front());
      end
    end
  end

  // {npower, nrst_enable, nrst, busy} for cycle t after the START cycle.
  function automatic logic [3:0] exp_pins(input int t, input int d0, input int d1, input int d2);
    if (t >= 1 && t <= d0)     return 4'b1101;
    if (t <= d0 + d1)          return 4'b0101;
    if (t <= d0 + d1 + d2)     return 4'b0011;
    return 4'b0010;
  endfunction

  task automatic bus_write(input logic [5:0] a, input int b, input logic [7:0] d, output int at);
    reg_address = a; reg_bytecnt = 16'(b); reg_datai = d;
    reg_write = 1'b1; reg_addrvalid = 1'b1; at = cyc;
    @(negedge clk);
    reg_write = 1'b0; reg_addrvalid = 1'b0;
  endtask

  task automatic wr(input logic [5:0] a, input int b, input logic [7:0] d);
    int at;
    bus_write(a, b, d, at);
  endtask

  task automatic bus_read(input logic [5:0] a, input int b, input logic [7:0] exp, input string name);
    reg_address = a; reg_bytecnt = 16'(b);
    reg_read = 1'b1; reg_addrvalid = 1'b1;
    rd_q.push_back(exp); rd_name_q.push_back(name);
    @(negedge clk);
    reg_read = 1'b0; reg_addrvalid = 1'b0;
  endtask

  task automatic set_times(input logic [15:0] off, input logic [15:0] rst, input logic [15:0] arm);
    wr(A_TIME, 0, off[7:0]); wr(A_TIME, 1, off[15:8]);
    wr(A_TIME, 2, rst[7:0]); wr(A_TIME, 3, rst[15:8]);
    wr(A_TIME, 4, arm[7:0]); wr(A_TIME, 5, arm[15:8]);
  endtask

  task automatic run_seq(input int d0, input int d1, input int d2, input int n, input string tag,
                         input int mid_t, input logic [7:0] mid_val);
    int s;
    bus_write(A_CTRL, 0, 8'h01, s);
    arm_q.push_back(s + d0 + d1 + d2);
    for (int t = 1; t <= n; t++) begin
      check($sformatf("%s pins t=%0d", tag, t),
            {28'd0, target_npower_o, nrst_enable_o, nrst_o, busy_o}, {28'd0, exp_pins(t, d0, d1, d2)});
      if (t == mid_t) wr(A_TIME, 0, mid_val);
      else            @(negedge clk);
    end
  endtask

  initial begin
    logic [7:0] dflt [6];
    int s;
    dflt = '{8'hE8, 8'h03, 8'h64, 8'h00, 8'h00, 8'h00};

    repeat (3) @(negedge clk);
    check("reset pins", {27'd0, target_npower_o, nrst_enable_o, nrst_o, glitch_arm_o, busy_o}, 32'b00100);
    check("reset datao", {24'd0, reg_datao}, 32'd0);
    reset_i = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) bus_read(A_TIME, i, dflt[i], $sformatf("seqtime byte%0d", i));
    bus_read(A_TIME, 6, 8'h00, "seqtime out of range");
    bus_read(A_CTRL, 0, 8'h00, "status after reset");
    bus_read(6'd12, 0, 8'h00, "unmapped read");

    reg_hypaddress = 6'd46; #1 check("hyplen 46", reg_hyplen, 32'd6);
    reg_hypaddress = 6'd45; #1 check("hyplen 45", reg_hyplen, 32'd1);
    reg_hypaddress = 6'd12; #1 check("hyplen 12", reg_hyplen, 32'd0);
    @(negedge clk);

    wr(A_CTRL, 1, 8'h01);
    check("out of range start ignored", {31'd0, busy_o}, 32'd0);

    // off=2, rst=1, arm=3 at 4 clk/tick: 12, 8, 16 cycles.
    set_times(16'd2, 16'd1, 16'd3);
    run_seq(12, 8, 16, 40, "seq_a", -1, 8'h00);
    bus_read(A_CTRL, 0, 8'h10, "status done");
    wr(A_CTRL, 0, 8'h80);
    bus_read(A_CTRL, 0, 8'h00, "status cleared");

    set_times(16'd0, 16'd0, 16'd0);
    run_seq(1, 1, 1, 5, "seq_zero", -1, 8'h00);
    bus_read(A_CTRL, 0, 8'h10, "status done zero");
    wr(A_CTRL, 0, 8'h80);

    // Abort five cycles into a 44-cycle power-off phase.
    set_times(16'd10, 16'd0, 16'd0);
    bus_write(A_CTRL, 0, 8'h01, s);
    for (int t = 1; t <= 5; t++) begin
      check($sformatf("abort pins t=%0d", t),
            {28'd0, target_npower_o, nrst_enable_o, nrst_o, busy_o}, {28'd0, exp_pins(t, 44, 1, 1)});
      if (t < 5) @(negedge clk);
    end
    wr(A_CTRL, 0, 8'h02);
    check("pins after abort", {28'd0, target_npower_o, nrst_enable_o, nrst_o, busy_o}, 32'b0010);
    repeat (3) @(negedge clk);
    bus_read(A_CTRL, 0, 8'h20, "status aborted");
    wr(A_CTRL, 0, 8'h80);
    bus_read(A_CTRL, 0, 8'h00, "status abort cleared");

    // off_time rewritten during RST_HOLD applies only to the next run.
    set_times(16'd2, 16'd1, 16'd0);
    run_seq(12, 8, 1, 24, "seq_old", 14, 8'h07);
    bus_read(A_TIME, 0, 8'h07, "off_time rewritten");
    run_seq(32, 8, 1, 44, "seq_new", -1, 8'h00);

    // Asynchronous reset while holding nRST.
    set_times(16'd0, 16'd1, 16'd0);
    bus_write(A_CTRL, 0, 8'h01, s);
    for (int t = 1; t <= 4; t++) begin
      check($sformatf("pre-reset pins t=%0d", t),
            {28'd0, target_npower_o, nrst_enable_o, nrst_o, busy_o}, {28'd0, exp_pins(t, 1, 8, 1)});
      if (t < 4) @(negedge clk);
    end
    #2 reset_i = 1'b1;
    #1 check("async reset pins", {27'd0, target_npower_o, nrst_enable_o, nrst_o, glitch_arm_o, busy_o}, 32'b00100);
    @(negedge clk);
    @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);
    bus_read(A_TIME, 0, 8'hE8, "off_time restored by reset");
    bus_read(A_CTRL, 0, 8'h00, "status after mid reset");
    set_times(16'd0, 16'd0, 16'd0);
    run_seq(1, 1, 1, 5, "seq_after_reset", -1, 8'h00);

    repeat (4) @(negedge clk);
    check("arm expectations left", arm_q.size(), 32'd0);
    check("read expectations left", rd_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
